des_decrypt_iter: RTL and testbench

Iterative DES decryption engine: accepts one 64-bit ciphertext block and 64-bit key over a valid/ready handshake, runs the 16 Feistel rounds over multiple clock cycles using the team's existing `feistel_function` block, and presents the 64-bit plaintext on a valid/ready output. It is the receive-side counterpart to the pipelined encryption round chain. It generates decryption subkeys K16..K1 on the fly from the key, using right rotations of C/D, so no key RAM is needed. It is area-optimised: one block in flight, R rounds of datapath per cycle.

---
 rtl/des_decrypt_iter_if.sv | 34 +++
 rtl/des_decrypt_iter.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_des_decrypt_iter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_decrypt_iter_if.sv
// Handshake bundle for the iterative DES engine.
// in_encrypt exists only when DES_DEC_ENCRYPT_EN is defined.
interface des_decrypt_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [63:0] in_key;
`ifdef DES_DEC_ENCRYPT_EN
    logic        in_encrypt;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    modport master (
        output in_valid, in_data, in_key,
`ifdef DES_DEC_ENCRYPT_EN
        output in_encrypt,
`endif
        input  in_ready,
        input  out_valid, out_data,
        output out_ready
    );

    modport slave (
        input  in_valid, in_data, in_key,
`ifdef DES_DEC_ENCRYPT_EN
        input  in_encrypt,
`endif
        output in_ready,
        output out_valid, out_data,
        input  out_ready
    );
endinterface

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption, ROUNDS_PER_CYCLE rounds per clock, subkeys on the fly.
// Optional DES_DEC_ENCRYPT_EN adds in_encrypt to run forward (encrypt) key order.
module des_decrypt_iter #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input logic              clk,
    input logic              rstn,
    des_decrypt_iter_if.slave bus
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8 ||
          ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam logic [4:0] STEP = 5'(ROUNDS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41, 9, 49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5,
        4, 5, 6, 7, 8, 9,
        8, 9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32, 1
    };

    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17,
        1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9,
        19, 13, 30, 6, 22, 11, 4, 25
    };

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9,
        1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27,
        19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
        7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29,
        21, 13, 5, 28, 20, 12, 4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5,
        3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8,
        16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Index = {box, row(b1,b6), col(b2..b5)}
    localparam int SBOX_T [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11
    };

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-IP_T[i]];
        return o;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-FP_T[i]];
        return o;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] o;
        for (int i = 0; i < 56; i++) o[55-i] = x[64-PC1_T[i]];
        return o;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[47-i] = x[56-PC2_T[i]];
        return o;
    endfunction

    function automatic logic [31:0] feistel_function(
        input logic [31:0] r,
        input logic [47:0] k
    );
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] o;
        logic [5:0]  b;
        logic [8:0]  idx;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            b   = x[47-6*i -: 6];
            idx = {3'(i), b[5], b[0], b[4:1]};
            s[31-4*i -: 4] = 4'(SBOX_T[idx]);
        end
        for (int i = 0; i < 32; i++) o[31-i] = s[32-P_T[i]];
        return o;
    endfunction

    // Right rotation before decrypt round j: 0 for j=1, else s(18-j)
    function automatic logic [1:0] rot_r_amt(input logic [4:0] j);
        if (j == 5'd1) return 2'd0;
        if (j == 5'd2 || j == 5'd9 || j == 5'd16) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [27:0] rotr28(
        input logic [27:0] x,
        input logic [1:0]  n
    );
        logic [27:0] o;
        unique case (n)
            2'd1:    o = {x[0], x[27:1]};
            2'd2:    o = {x[1:0], x[27:2]};
            default: o = x;
        endcase
        return o;
    endfunction

`ifdef DES_DEC_ENCRYPT_EN
    function automatic logic [1:0] rot_l_amt(input logic [4:0] j);
        if (j == 5'd1 || j == 5'd2 || j == 5'd9 || j == 5'd16) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [27:0] rotl28(
        input logic [27:0] x,
        input logic [1:0]  n
    );
        logic [27:0] o;
        unique case (n)
            2'd1:    o = {x[26:0], x[27]};
            2'd2:    o = {x[25:0], x[27:26]};
            default: o = x;
        endcase
        return o;
    endfunction
`endif

    state_t      state_q;
    logic [31:0] l_q, r_q, l_d, r_d;
    logic [27:0] c_q, d_q, c_d, d_d;
    logic [4:0]  cnt_q;
    logic        in_ready_q;
    logic        out_valid_q;
`ifdef DES_DEC_ENCRYPT_EN
    logic        enc_q;
`endif

    // Key parity bits are architecturally ignored
    logic unused_parity;
    assign unused_parity = ^{bus.in_key[56], bus.in_key[48],
                             bus.in_key[40], bus.in_key[32],
                             bus.in_key[24], bus.in_key[16],
                             bus.in_key[8],  bus.in_key[0]};

    always_comb begin : rounds
        logic [31:0] t;
        logic [4:0]  j;
        l_d = l_q;
        r_d = r_q;
        c_d = c_q;
        d_d = d_q;
        t   = '0;
        j   = '0;
        for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
            j = cnt_q + 5'(k + 1);
`ifdef DES_DEC_ENCRYPT_EN
            if (enc_q) begin
                c_d = rotl28(c_d, rot_l_amt(j));
                d_d = rotl28(d_d, rot_l_amt(j));
            end else begin
                c_d = rotr28(c_d, rot_r_amt(j));
                d_d = rotr28(d_d, rot_r_amt(j));
            end
`else
            c_d = rotr28(c_d, rot_r_amt(j));
            d_d = rotr28(d_d, rot_r_amt(j));
`endif
            t   = l_d ^ feistel_function(r_d, perm_pc2({c_d, d_d}));
            l_d = r_d;
            r_d = t;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef DES_DEC_ENCRYPT_EN
            enc_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        {l_q, r_q} <= perm_ip(bus.in_data);
                        {c_q, d_q} <= perm_pc1(bus.in_key);
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
`ifdef DES_DEC_ENCRYPT_EN
                        enc_q      <= bus.in_encrypt;
`endif
                    end
                end
                RUN: begin
                    l_q   <= l_d;
                    r_q   <= r_d;
                    c_q   <= c_d;
                    d_q   <= d_d;
                    cnt_q <= cnt_q + STEP;
                    if (cnt_q + STEP == 5'd16) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = perm_fp({r_q, l_q});

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed known-answer bench for des_decrypt_iter at 1, 4 and 16 rounds/cycle.
// Latency is counted in rising edges including the accepting edge.
module tb_des_decrypt_iter;

    localparam logic [63:0] CT1 = 64'h85E813540F0AB405;
    localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT2 = 64'h0000000000000000;
    localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PT2 = 64'h8787878787878787;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    des_decrypt_iter_if i1 ();
    des_decrypt_iter_if i4 ();
    des_decrypt_iter_if i16 ();

    des_decrypt_iter #(.ROUNDS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rstn(rstn), .bus(i1)
    );
    des_decrypt_iter #(.ROUNDS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rstn(rstn), .bus(i4)
    );
    des_decrypt_iter #(.ROUNDS_PER_CYCLE(16)) dut16 (
        .clk(clk), .rstn(rstn), .bus(i16)
    );

    task automatic init_inputs();
        i1.in_valid = 0; i1.in_data = '0; i1.in_key = '0; i1.out_ready = 0;
        i4.in_valid = 0; i4.in_data = '0; i4.in_key = '0; i4.out_ready = 0;
        i16.in_valid = 0; i16.in_data = '0; i16.in_key = '0; i16.out_ready = 0;
`ifdef DES_DEC_ENCRYPT_EN
        i1.in_encrypt = 0; i4.in_encrypt = 0; i16.in_encrypt = 0;
`endif
    endtask

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic accept1(input logic [63:0] d, input logic [63:0] k,
                           output bit ok);
        i1.in_data = d;
        i1.in_key = k;
        i1.in_valid = 1;
        ok = 0;
        for (int n = 0; n < 60 && !ok; n++) begin
            ok = i1.in_ready;
            @(posedge clk); #1;
        end
        i1.in_valid = 0;
    endtask

    task automatic wait_out1(output int edges);
        edges = 0;
        while (!i1.out_valid && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic pop1();
        i1.out_ready = 1;
        @(posedge clk); #1;
        i1.out_ready = 0;
    endtask

    task automatic test_reset();
        #1 rstn = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (i1.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b need 1", i1.in_ready);
        end
        n_checks++;
        if (i1.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b need 0", i1.out_valid);
        end
        n_checks++;
        if (i1.out_data !== 64'h0) begin
            n_fail++; $display("FAIL reset_out_data: got %h need 0", i1.out_data);
        end
        @(negedge clk) rstn = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_kat1();
        bit ok;
        int e;
        accept1(CT1, K1, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL kat1_accept: got 0 need 1");
        end
        wait_out1(e);
        n_checks++;
        if (e + 1 != 17) begin
            n_fail++; $display("FAIL kat1_latency: got %0d need 17", e + 1);
        end
        n_checks++;
        if (i1.out_data !== PT1) begin
            n_fail++; $display("FAIL kat1_data: got %h need %h", i1.out_data, PT1);
        end
        n_checks++;
        if (i1.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL kat1_busy_ready: got %b need 0", i1.in_ready);
        end
        pop1();
        n_checks++;
        if (i1.out_valid !== 1'b0 || i1.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL kat1_release: got v=%b r=%b need v=0 r=1",
                     i1.out_valid, i1.in_ready);
        end
    endtask

    task automatic test_rounds_param();
        int e1, e4, e16;
        logic [63:0] d1, d4, d16;
        e1 = -1; e4 = -1; e16 = -1;
        d1 = '0; d4 = '0; d16 = '0;
        i1.in_data = CT2;  i1.in_key = K2;  i1.in_valid = 1;
        i4.in_data = CT2;  i4.in_key = K2;  i4.in_valid = 1;
        i16.in_data = CT2; i16.in_key = K2; i16.in_valid = 1;
        @(posedge clk); #1;
        i1.in_valid = 0; i4.in_valid = 0; i16.in_valid = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (e1 < 0 && i1.out_valid) begin e1 = n; d1 = i1.out_data; end
            if (e4 < 0 && i4.out_valid) begin e4 = n; d4 = i4.out_data; end
            if (e16 < 0 && i16.out_valid) begin e16 = n; d16 = i16.out_data; end
        end
        n_checks++;
        if (e1 + 1 != 17) begin
            n_fail++; $display("FAIL rpc1_latency: got %0d need 17", e1 + 1);
        end
        n_checks++;
        if (e4 + 1 != 5) begin
            n_fail++; $display("FAIL rpc4_latency: got %0d need 5", e4 + 1);
        end
        n_checks++;
        if (e16 + 1 != 2) begin
            n_fail++; $display("FAIL rpc16_latency: got %0d need 2", e16 + 1);
        end
        n_checks++;
        if (d1 !== PT2) begin
            n_fail++; $display("FAIL rpc1_data: got %h need %h", d1, PT2);
        end
        n_checks++;
        if (d4 !== PT2) begin
            n_fail++; $display("FAIL rpc4_data: got %h need %h", d4, PT2);
        end
        n_checks++;
        if (d16 !== PT2) begin
            n_fail++; $display("FAIL rpc16_data: got %h need %h", d16, PT2);
        end
        i1.out_ready = 1; i4.out_ready = 1; i16.out_ready = 1;
        @(posedge clk); #1;
        i1.out_ready = 0; i4.out_ready = 0; i16.out_ready = 0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int e;
        int bad;
        logic [63:0] hold;
        accept1(CT2, K2, ok);
        wait_out1(e);
        hold = i1.out_data;
        n_checks++;
        if (hold !== PT2) begin
            n_fail++; $display("FAIL bp_data: got %h need %h", hold, PT2);
        end
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (i1.out_valid !== 1'b1 || i1.out_data !== hold ||
                i1.in_ready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL bp_hold: got %0d bad cycles need 0", bad);
        end
        pop1();
        n_checks++;
        if (i1.out_valid !== 1'b0 || i1.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got v=%b r=%b need v=0 r=1",
                     i1.out_valid, i1.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int  e, acc_n, hs_n, acc_at_hs1, e_hs1, e_acc2;
        logic [63:0] d_hs1, d_hs2, dsamp;
        bit  acc, hs;
        e = 0; acc_n = 0; hs_n = 0; acc_at_hs1 = -1;
        e_hs1 = -1; e_acc2 = -1; d_hs1 = '0; d_hs2 = '0;
        i1.out_ready = 1;
        i1.in_data = CT1; i1.in_key = K1; i1.in_valid = 1;
        while (hs_n < 2 && e < 200) begin
            acc = i1.in_valid && i1.in_ready;
            hs = i1.out_valid && i1.out_ready;
            dsamp = i1.out_data;
            @(posedge clk); #1;
            e++;
            if (hs) begin
                hs_n++;
                if (hs_n == 1) begin
                    e_hs1 = e; d_hs1 = dsamp; acc_at_hs1 = acc_n;
                end else d_hs2 = dsamp;
            end
            if (acc) begin
                acc_n++;
                if (acc_n == 1) begin
                    i1.in_data = CT2; i1.in_key = K2;
                end else begin
                    e_acc2 = e; i1.in_valid = 0;
                end
            end
        end
        i1.in_valid = 0;
        i1.out_ready = 0;
        n_checks++;
        if (hs_n != 2) begin
            n_fail++; $display("FAIL b2b_handshakes: got %0d need 2", hs_n);
        end
        n_checks++;
        if (acc_at_hs1 != 1) begin
            n_fail++; $display("FAIL b2b_busy_accepts: got %0d need 1", acc_at_hs1);
        end
        n_checks++;
        if (e_acc2 - e_hs1 != 1) begin
            n_fail++; $display("FAIL b2b_gap: got %0d need 1", e_acc2 - e_hs1);
        end
        n_checks++;
        if (d_hs1 !== PT1) begin
            n_fail++; $display("FAIL b2b_data1: got %h need %h", d_hs1, PT1);
        end
        n_checks++;
        if (d_hs2 !== PT2) begin
            n_fail++; $display("FAIL b2b_data2: got %h need %h", d_hs2, PT2);
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int e;
        int seen;
        accept1(CT1, K1, ok);
        repeat (7) @(posedge clk);
        #1;
        n_checks++;
        if (i1.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_busy: got %b need 0", i1.in_ready);
        end
        #2 rstn = 0;
        #1;
        n_checks++;
        if (i1.out_valid !== 1'b0 || i1.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_async: got v=%b r=%b need v=0 r=1",
                     i1.out_valid, i1.in_ready);
        end
        @(negedge clk) rstn = 1;
        seen = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk); #1;
            if (i1.out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL rst_no_output: got %0d need 0", seen);
        end
        accept1(CT1, K1, ok);
        wait_out1(e);
        n_checks++;
        if (i1.out_data !== PT1 || e + 1 != 17) begin
            n_fail++;
            $display("FAIL rst_after_kat: got %h/%0d need %h/17",
                     i1.out_data, e + 1, PT1);
        end
        pop1();
    endtask

`ifdef DES_DEC_ENCRYPT_EN
    task automatic test_encrypt();
        bit ok;
        int e;
        i1.in_encrypt = 1;
        accept1(PT1, K1, ok);
        i1.in_encrypt = 0;
        wait_out1(e);
        n_checks++;
        if (i1.out_data !== CT1) begin
            n_fail++; $display("FAIL enc_data: got %h need %h", i1.out_data, CT1);
        end
        pop1();
    endtask
`endif

    initial begin
        init_inputs();
        test_reset();
        test_kat1();
        test_rounds_param();
        test_backpressure();
        test_back_to_back();
        @(posedge clk); #1;
        test_reset_mid_run();
`ifdef DES_DEC_ENCRYPT_EN
        test_encrypt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
